// File: rtl/mbist_march_ctrl_pkg.sv
// Shared definitions for the March C- MBIST controller: state encoding,
// element tables and pipeline timing constants.
package mbist_march_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int ELEM_CNT     = 6;
  localparam int RD_LATENCY   = 2;
  localparam int WDATA_LEAD   = 1;
  localparam int DRAIN_CYCLES = RD_LATENCY;

  // Element tables, bit i = element Mi. Bits 7:6 are padding so a 3-bit
  // element index never selects out of range.
  //   M0 up(w0) M1 up(r0,w1) M2 up(r1,w0) M3 dn(r0,w1) M4 dn(r1,w0) M5 up(r0)
  localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
  localparam logic [7:0] ELEM_TWO_OP = 8'b0001_1110;
  localparam logic [7:0] OP0_WRITE   = 8'b0000_0001;
  localparam logic [7:0] OP0_VAL     = 8'b0001_0100;
  localparam logic [7:0] OP1_VAL     = 8'b0000_1010;
  localparam logic [2:0] LAST_ELEM   = 3'(ELEM_CNT - 1);

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Memory-side bus of the MBIST controller. The controller is the master;
// the memory under test (or its wrapper) is the slave.
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output write_read, output address, output wdata, input rdata);
  modport slave  (input write_read, input address, input wdata, output rdata);
endinterface

// File: rtl/mbist_march_ctrl_cmp_pipe.sv
// mbist_cmp_pipe: carries expected data and read-valid alongside the memory
// read latency, compares the returning word and keeps the pass flag.
// With MBIST_DIAG_EN defined it also records the first miscompare.
module mbist_cmp_pipe
  import mbist_march_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  rd_valid,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic [DATA_WIDTH-1:0] rdata,
`ifdef MBIST_DIAG_EN
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [2:0]            rd_elem,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data,
`endif
  output logic                  pass
);

  logic [RD_LATENCY-1:0] vld_p;
  logic [DATA_WIDTH-1:0] exp_p [RD_LATENCY];
  logic                  miscmp;

  assign miscmp = vld_p[RD_LATENCY-1] && (rdata != exp_p[RD_LATENCY-1]);

  // Delay the read tag by the memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int i = 0; i < RD_LATENCY; i++) exp_p[i] <= '0;
    end else if (clr) begin
      vld_p <= '0;
    end else begin
      vld_p    <= {vld_p[RD_LATENCY-2:0], rd_valid};
      exp_p[0] <= exp_data;
      for (int i = 1; i < RD_LATENCY; i++) exp_p[i] <= exp_p[i-1];
    end
  end

  // Pass is sticky-low once any compare fails; restart re-arms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pass <= 1'b0;
    else if (clr)    pass <= 1'b1;
    else if (miscmp) pass <= 1'b0;
  end

`ifdef MBIST_DIAG_EN
  logic [ADDR_WIDTH-1:0] addr_p [RD_LATENCY];
  logic [2:0]            elem_p [RD_LATENCY];
  logic                  fail_seen;

  // Address/element tags travel with the expected data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        addr_p[i] <= '0;
        elem_p[i] <= '0;
      end
    end else begin
      addr_p[0] <= rd_addr;
      elem_p[0] <= rd_elem;
      for (int i = 1; i < RD_LATENCY; i++) begin
        addr_p[i] <= addr_p[i-1];
        elem_p[i] <= elem_p[i-1];
      end
    end
  end

  // Capture only the first miscompare of a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else if (clr) begin
      fail_seen <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else if (miscmp && !fail_seen) begin
      fail_seen <= 1'b1;
      fail_addr <= addr_p[RD_LATENCY-1];
      fail_elem <= elem_p[RD_LATENCY-1];
      fail_data <= rdata;
    end
  end
`endif

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- memory BIST sequencer (backgrounds 0 and 1).
// Optional diagnostics (first-fail address/element/data) with MBIST_DIAG_EN.
//
// state | meaning
// IDLE  | waiting for start, bus read-only
// PREP  | one-cycle lead so wdata for the first write is already on the bus
// RUN   | one memory operation per cycle, 10N total
// DRAIN | wait out the read latency of the final reads
// DONE  | result valid, waiting for restart
module mbist_march_ctrl
  import mbist_march_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  mbist_march_ctrl_if.master    mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(CAPACITY);

  state_t                state;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  cur_rd;
  logic                  cur_val;
  logic                  cur_last;
  logic                  drain_cnt;
`ifdef MBIST_DIAG_EN
  logic [2:0]            cur_elem;
`endif

  // Cursor pointing at the operation to be issued in the next cycle.
  logic [2:0]            nxt_elem;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic                  nxt_ph;
  logic                  nxt_wr;
  logic                  nxt_val;
  logic                  nxt_last;
  logic                  nxt_elem_end;

  logic [2:0]            adv_elem;
  logic [ADDR_WIDTH-1:0] adv_addr;
  logic                  adv_ph;
  logic                  adv_val;
  logic                  cmp_clr;

  assign mem.write_read = wr_q;
  assign mem.address    = addr_q;
  assign mem.wdata      = wdata_q;

  assign nxt_wr       = nxt_ph | OP0_WRITE[nxt_elem];
  assign nxt_val      = nxt_ph ? OP1_VAL[nxt_elem] : OP0_VAL[nxt_elem];
  assign nxt_elem_end = ELEM_DOWN[nxt_elem] ? (nxt_addr == '0) : (nxt_addr == ADDR_TOP);
  assign nxt_last     = (nxt_elem == LAST_ELEM) && (nxt_addr == ADDR_TOP);
  assign adv_val      = adv_ph ? OP1_VAL[adv_elem] : OP0_VAL[adv_elem];
  assign cmp_clr      = start && (state == ST_IDLE || state == ST_DONE);

  // Step the cursor: second op of the element, next address, or next element.
  always_comb begin
    adv_elem = nxt_elem;
    adv_addr = nxt_addr;
    adv_ph   = 1'b0;
    if (!nxt_ph && ELEM_TWO_OP[nxt_elem]) begin
      adv_ph = 1'b1;
    end else if (nxt_elem_end) begin
      adv_elem = nxt_elem + 3'd1;
      adv_addr = ELEM_DOWN[adv_elem] ? ADDR_TOP : '0;
    end else if (ELEM_DOWN[nxt_elem]) begin
      adv_addr = nxt_addr - ADDR_WIDTH'(1);
    end else begin
      adv_addr = nxt_addr + ADDR_WIDTH'(1);
    end
  end

  // Main sequencer with registered bus and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_rd    <= 1'b0;
      cur_val   <= 1'b0;
      cur_last  <= 1'b0;
      drain_cnt <= 1'b0;
      nxt_elem  <= '0;
      nxt_addr  <= '0;
      nxt_ph    <= 1'b0;
`ifdef MBIST_DIAG_EN
      cur_elem  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          wr_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          cur_rd  <= 1'b0;
          if (start) begin
            state    <= ST_PREP;
            busy     <= 1'b1;
            done     <= 1'b0;
            nxt_elem <= '0;
            nxt_addr <= '0;
            nxt_ph   <= 1'b0;
            cur_last <= 1'b0;
            wdata_q  <= {DATA_WIDTH{OP0_VAL[0]}};
          end
        end
        ST_PREP, ST_RUN: begin
          if (state == ST_RUN && cur_last) begin
            state     <= ST_DRAIN;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cur_rd    <= 1'b0;
            drain_cnt <= 1'b0;
          end else begin
            state    <= ST_RUN;
            wr_q     <= nxt_wr;
            addr_q   <= nxt_addr;
            cur_rd   <= !nxt_wr;
            cur_val  <= nxt_val;
            cur_last <= nxt_last;
`ifdef MBIST_DIAG_EN
            cur_elem <= nxt_elem;
`endif
            nxt_elem <= adv_elem;
            nxt_addr <= adv_addr;
            nxt_ph   <= adv_ph;
            // Memory registers wdata, so present the following op's data now.
            wdata_q  <= {DATA_WIDTH{adv_val}};
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 1'(DRAIN_CYCLES - 1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          wr_q  <= 1'b0;
        end
      endcase
    end
  end

  mbist_cmp_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cmp_clr),
    .rd_valid  (cur_rd),
    .exp_data  ({DATA_WIDTH{cur_val}}),
    .rdata     (mem.rdata),
`ifdef MBIST_DIAG_EN
    .rd_addr   (addr_q),
    .rd_elem   (cur_elem),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_data (fail_data),
`endif
    .pass      (pass)
  );

`ifndef MBIST_DIAG_EN
  assign fail_addr = '0;
  assign fail_elem = '0;
  assign fail_data = '0;
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: fault-injecting memory model, March C- reference.
module tb_mbist_march_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CAP = 15;
  localparam int N = CAP + 1;
  localparam int NOPS = 10 * N;
  localparam int DONE_CYC = NOPS + 3;
  localparam int TIMEOUT = 400;
  localparam int K_NONE = 0, K_SA0 = 1, K_SA1 = 2, K_CPL = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [2:0] fail_elem;
  logic [DW-1:0] fail_data;

  mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem(mif),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // fault configuration and memory image
  int f_kind = K_NONE;
  int f_addr = 0;
  int f_bit = 0;
  logic mem_load = 1'b0;
  logic [DW-1:0] init_mem [N];
  logic [DW-1:0] bus_mem [N];
  logic [DW-1:0] wd_q, rd1, rdata_q;

  // expected operation stream
  bit exp_wr [NOPS];
  int exp_addr [NOPS];
  bit exp_val [NOPS];
  int exp_elem [NOPS];

  function automatic logic [DW-1:0] stored(int a, logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (f_kind == K_SA0 && a == f_addr) r[f_bit] = 1'b0;
    if (f_kind == K_SA1 && a == f_addr) r[f_bit] = 1'b1;
    return r;
  endfunction

  function automatic bit couples(int a, logic [DW-1:0] old_v, logic [DW-1:0] new_v);
    return (f_kind == K_CPL) && (a == f_addr) && old_v[f_bit] && !new_v[f_bit];
  endfunction

  function automatic int dg(int v);
`ifdef MBIST_DIAG_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Memory: wdata registered one cycle, two-cycle read latency.
  always @(posedge clk) begin
    int a;
    logic [DW-1:0] old_v, new_v;
    rd1 <= bus_mem[mif.address];
    rdata_q <= rd1;
    if (mem_load) begin
      for (int i = 0; i < N; i++) bus_mem[i] = init_mem[i];
    end else if (mif.write_read) begin
      a = int'(mif.address);
      old_v = bus_mem[a];
      new_v = stored(a, wd_q);
      bus_mem[a] = new_v;
      if (couples(a, old_v, new_v)) bus_mem[f_addr + 1][f_bit] = 1'b0;
    end
    wd_q <= mif.wdata;
  end
  assign mif.rdata = rdata_q;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // March C- as a flat list: element direction and op codes (bit1 write, bit0 value).
  task automatic build_ops();
    int dir [6] = '{0, 0, 0, 1, 1, 0};
    int nop [6] = '{1, 2, 2, 2, 2, 1};
    int opc [6][2] = '{'{2, 0}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, 0}};
    int k = 0;
    for (int e = 0; e < 6; e++)
      for (int s = 0; s < N; s++)
        for (int o = 0; o < nop[e]; o++) begin
          exp_addr[k] = (dir[e] != 0) ? CAP - s : s;
          exp_wr[k] = ((opc[e][o] >> 1) & 1) != 0;
          exp_val[k] = (opc[e][o] & 1) != 0;
          exp_elem[k] = e;
          k++;
        end
  endtask

  // Reference result: replay the op list on a faulty memory image.
  task automatic model_run(output bit e_pass, output int e_addr, output int e_elem, output int e_data);
    logic [DW-1:0] mm [N];
    logic [DW-1:0] want, old_v, new_v;
    int a;
    e_pass = 1; e_addr = 0; e_elem = 0; e_data = 0;
    for (int i = 0; i < N; i++) mm[i] = init_mem[i];
    for (int k = 0; k < NOPS; k++) begin
      a = exp_addr[k];
      want = {DW{exp_val[k]}};
      if (exp_wr[k]) begin
        old_v = mm[a];
        new_v = stored(a, want);
        mm[a] = new_v;
        if (couples(a, old_v, new_v)) mm[f_addr + 1][f_bit] = 1'b0;
      end else if (mm[a] !== want) begin
        if (e_pass) begin
          e_addr = a; e_elem = exp_elem[k]; e_data = int'(mm[a]);
        end
        e_pass = 0;
      end
    end
  endtask

  task automatic load_mem(input bit rand_fill);
    for (int i = 0; i < N; i++) init_mem[i] = rand_fill ? DW'($urandom) : '0;
    @(negedge clk); mem_load = 1'b1;
    @(negedge clk); mem_load = 1'b0;
  endtask

  // One full run; checks bus sequence, wdata lead and done timing.
  task automatic run_test(input string tag, input bit hold);
    int bus_err = 0;
    int done_cyc = -1;
    logic [DW-1:0] prev_wd;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    prev_wd = mif.wdata;
    if (!hold) start = 1'b0;
    check({tag, ".prep_busy_done"}, {busy, done}, 2'b10);
    for (int cyc = 1; cyc <= TIMEOUT; cyc++) begin
      @(posedge clk); #1;
      if (hold && cyc == NOPS + 1) start = 1'b0;
      if (cyc <= NOPS) begin
        if (mif.write_read !== exp_wr[cyc-1] || int'(mif.address) != exp_addr[cyc-1]) bus_err++;
        else if (exp_wr[cyc-1] && prev_wd !== {DW{exp_val[cyc-1]}}) bus_err++;
        if (busy !== 1'b1) bus_err++;
      end
      prev_wd = mif.wdata;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    check({tag, ".bus_errors"}, bus_err, 0);
    check({tag, ".done_cycle"}, done_cyc, DONE_CYC);
    check({tag, ".done_idle_bus"}, {busy, mif.write_read}, 2'b00);
  endtask

  typedef struct {
    int kind; int faddr; int fbit; bit hold;
    bit e_pass; int e_addr; int e_elem; int e_data;
  } vec_t;

  initial begin
    vec_t tv [4];
    bit m_pass;
    int m_addr, m_elem, m_data;

    tv[0] = '{K_NONE, 0, 0, 1'b0, 1'b1, 0, 0, 0};
    tv[1] = '{K_SA0, 5, 0, 1'b0, 1'b0, 5, 2, 'hFE};
    tv[2] = '{K_CPL, 6, 4, 1'b0, 1'b0, 7, 2, 'hEF};
    tv[3] = '{K_NONE, 0, 0, 1'b1, 1'b1, 0, 0, 0};

    build_ops();
    rst_n = 1'b0;
    start = 1'b0;
    #2;
    check("reset_outputs", {mif.write_read, mif.address, mif.wdata, busy, done, pass,
                            fail_addr, fail_elem, fail_data}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("idle_readonly", {mif.write_read, busy, done}, 3'b000);

    for (int i = 0; i < 4; i++) begin
      f_kind = tv[i].kind; f_addr = tv[i].faddr; f_bit = tv[i].fbit;
      load_mem(1'b1);
      run_test($sformatf("vec%0d", i), tv[i].hold);
      check($sformatf("vec%0d.pass", i), pass, tv[i].e_pass);
      check($sformatf("vec%0d.fail_addr", i), fail_addr, dg(tv[i].e_addr));
      check($sformatf("vec%0d.fail_elem", i), fail_elem, dg(tv[i].e_elem));
      check($sformatf("vec%0d.fail_data", i), fail_data, dg(tv[i].e_data));
    end

    // random faults against the reference model
    for (int r = 0; r < 6; r++) begin
      f_kind = int'($urandom_range(K_SA0, K_CPL));
      f_addr = (f_kind == K_CPL) ? int'($urandom_range(0, CAP - 1)) : int'($urandom_range(0, CAP));
      f_bit = int'($urandom_range(0, DW - 1));
      load_mem(1'b1);
      model_run(m_pass, m_addr, m_elem, m_data);
      run_test($sformatf("rnd%0d", r), 1'b0);
      check($sformatf("rnd%0d.pass", r), pass, m_pass);
      check($sformatf("rnd%0d.fail_addr", r), fail_addr, dg(m_addr));
      check($sformatf("rnd%0d.fail_elem", r), fail_elem, dg(m_elem));
      check($sformatf("rnd%0d.fail_data", r), fail_data, dg(m_data));
    end

    // reset in cycle 50 of a faulty run, then a clean fresh run
    f_kind = K_SA0; f_addr = 3; f_bit = 2;
    load_mem(1'b0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midrun_reset_outputs", {mif.write_read, mif.address, mif.wdata, busy, done, pass,
                                      fail_addr, fail_elem, fail_data}, 0);
    @(negedge clk); rst_n = 1'b1;
    f_kind = K_NONE;
    load_mem(1'b1);
    run_test("after_reset", 1'b0);
    check("after_reset.pass", pass, 1);
    check("after_reset.fail_addr", fail_addr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
